// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes and FSM state encoding shared by alu_seq and its multiplier
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOTA  = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add unsigned multiplier, one partial-product bit per cycle
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   product
);

    // The load cycle already consumes the first multiplier bit, so WIDTH-1
    // further steps remain and the product is final once busy drops.
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH-1:0]   step_mcand;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH:0]     step_sum;

    // One shift-add step: conditionally add the multiplicand to the high half, then shift right.
    always_comb begin
        step_mcand = start ? a : mcand_q;
        step_hi    = start ? {WIDTH{1'b0}} : acc_q[2*WIDTH-1:WIDTH];
        step_lo    = start ? b : acc_q[WIDTH-1:0];
        step_sum   = {1'b0, step_hi} +
                     (step_lo[0] ? {1'b0, step_mcand} : {(WIDTH+1){1'b0}});
        acc_d      = {step_sum, step_lo[WIDTH-1:1]};
    end

    // Load operands on start, then iterate until the step counter runs out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            mcand_q <= a;
            acc_q   <= acc_d;
            cnt_q   <= CW'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_q - CW'(1);
        end
    end

    assign busy    = (cnt_q != '0);
    assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered handshake ALU; ALU_MUL_EN enables the multi-cycle multiply
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             ovf
);

    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] r_q;
    logic             zero_q;
    logic             carry_q;
    logic             sign_q;
    logic             ovf_q;

    logic             accept;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_o;

    logic [WIDTH-1:0] res_r;
    logic             res_z;
    logic             res_c;
    logic             res_s;
    logic             res_o;

    assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    // Single-cycle arithmetic/logic unit operating on the live operands at accept.
    always_comb begin
        b_eff   = (op == OP_SUB) ? ~b : b;
        add_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_r = add_sum[WIDTH-1:0];
                alu_c = add_sum[WIDTH];
                alu_o = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   alu_r = a & b;
            OP_OR:    alu_r = a | b;
            OP_XOR:   alu_r = a ^ b;
            OP_NOTA:  alu_r = ~a;
            OP_PASSB: alu_r = b;
            default:  alu_r = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic                 mul_start;
    logic                 mul_busy;
    logic [2*WIDTH-1:0]   mul_product;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     r_hi_q;

    assign mul_start = accept && (op == OP_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .product (mul_product)
    );
`endif

    // Select what gets registered as the result: the ALU, or the finished product while in MUL.
    always_comb begin
        res_r = alu_r;
        res_z = (alu_r == '0);
        res_c = alu_c;
        res_s = alu_r[WIDTH-1];
        res_o = alu_o;
`ifdef ALU_MUL_EN
        res_hi = '0;
        if (state_q == S_MUL) begin
            res_r  = mul_product[WIDTH-1:0];
            res_hi = mul_product[2*WIDTH-1:WIDTH];
            res_z  = (mul_product == '0);
            res_c  = 1'b0;
            res_s  = mul_product[2*WIDTH-1];
            res_o  = (mul_product[2*WIDTH-1:WIDTH] != '0);
        end
`endif
    end

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef ALU_MUL_EN
            r_hi_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        r_q         <= res_r;
                        zero_q      <= res_z;
                        carry_q     <= res_c;
                        sign_q      <= res_s;
                        ovf_q       <= res_o;
`ifdef ALU_MUL_EN
                        r_hi_q      <= res_hi;
                        // A multiply overrides the single-cycle completion above.
                        if (op == OP_MUL) begin
                            state_q     <= S_MUL;
                            out_valid_q <= 1'b0;
                        end
`endif
                    end else if ((state_q == S_DONE) && out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    if (!mul_busy) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        r_q         <= res_r;
                        r_hi_q      <= res_hi;
                        zero_q      <= res_z;
                        carry_q     <= res_c;
                        sign_q      <= res_s;
                        ovf_q       <= res_o;
                    end
                end
`endif
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign r         = r_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign sign      = sign_q;
    assign ovf       = ovf_q;
`ifdef ALU_MUL_EN
    assign r_hi      = r_hi_q;
`else
    assign r_hi      = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with randomized ops against an arithmetic model
module tb_alu_seq;

    localparam int W    = 8;
    localparam int M    = 1 << W;
    localparam int HALF = M / 2;
`ifdef ALU_MUL_EN
    localparam int MUL_LAT = W + 1;
`else
    localparam int MUL_LAT = 1;
`endif

    typedef logic [2*W+3:0] res_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] r;
    logic [W-1:0] r_hi;
    logic         zero;
    logic         carry;
    logic         sign;
    logic         ovf;

    res_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   rand_done = 1'b0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .r_hi      (r_hi),
        .zero      (zero),
        .carry     (carry),
        .sign      (sign),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input int ai, input int bi, input int opi);
        int sa, sb, sr, rv, hv, p;
        bit z, c, s, o;
        sa = (ai >= HALF) ? ai - M : ai;
        sb = (bi >= HALF) ? bi - M : bi;
        rv = 0; hv = 0; c = 0; o = 0; sr = 0; p = 0;
        case (opi)
            0: begin
                rv = (ai + bi) % M;
                c  = (ai + bi) >= M;
                sr = sa + sb;
                o  = (sr >= HALF) || (sr < -HALF);
            end
            1: begin
                rv = (ai - bi + M) % M;
                c  = (ai >= bi);
                sr = sa - sb;
                o  = (sr >= HALF) || (sr < -HALF);
            end
            2: rv = ai & bi;
            3: rv = ai | bi;
            4: rv = ai ^ bi;
            5: rv = M - 1 - ai;
            6: rv = bi;
            default: begin
`ifdef ALU_MUL_EN
                p  = ai * bi;
                rv = p % M;
                hv = p / M;
                o  = (hv != 0);
`endif
            end
        endcase
        z = (rv == 0) && (hv == 0);
        s = (opi == 7) ? (hv >= HALF) : (rv >= HALF);
        return {W'(hv), W'(rv), z, c, s, o};
    endfunction

    function automatic res_t got();
        return {r_hi, r, zero, carry, sign, ovf};
    endfunction

    task automatic check_res(input string name, input res_t act, input res_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {r_hi,r,z,c,s,o}=%h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive(input int ai, input int bi, input int opi);
        int  n;
        bit  ok;
        n  = 0;
        ok = 0;
        a = W'(ai); b = W'(bi); op = 3'(opi); in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else n++;
        end
        if (ok) exp_q.push_back(model(ai, bi, opi));
        else check_int("accept_timeout", n, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles from the accept edge until out_valid, then returns at posedge+1.
    task automatic check_latency(input string name, input int exp);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 60);
        check_int(name, n, exp);
        @(posedge clk); #1;
    endtask

    function automatic int pick();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return M - 1;
            2: return HALF;
            3: return HALF - 1;
            default: return int'($urandom_range(0, M - 1));
        endcase
    endfunction

    // Monitor: every cycle a result is presented it must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got %h, expected none", got());
                end else begin
                    check_res("result", got(), exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_res("reset_outputs", got(), '0);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;

        drive(8'hFF, 8'h01, 0);
        check_latency("add_latency", 1);
        drive(8'h80, 8'h01, 1);
        check_latency("sub_latency", 1);
        drive(8'hFF, 8'hFF, 7);
        check_latency("mul_latency", MUL_LAT);

        out_ready = 1'b0;
        drive(8'hF0, 8'hFF, 4);
        repeat (5) begin
            @(negedge clk);
            check_int("stall_in_ready", int'(in_ready), 0);
            check_int("stall_out_valid", int'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(8'h11, 8'h22, 0);
        check_latency("add_after_stall_latency", 1);

        drive(8'h12, 8'h34, 7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_res("midmul_reset_outputs", got(), '0);
        check_int("midmul_reset_out_valid", int'(out_valid), 0);
        check_int("midmul_reset_in_ready", int'(in_ready), 1);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        drive(8'h3C, 8'h0F, 2);
        check_latency("and_after_reset_latency", 1);

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    drive(pick(), pick(), int'($urandom_range(0, 7)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_int("drain_pending", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
